// File: rtl/apb_arb_pkg.sv
// Shared definitions for the two-requester APB arbiter.
//   arb_state_e        : arbiter FSM states
//   TIMEOUT_CYCLES_DEF : default watchdog limit, in ACCESS cycles
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 1023;

endpackage

// File: rtl/apb_requester_arbiter_if.sv
// APB bus bundle shared by the upstream requester ports and the downstream
// completer port.
//   master : requester side (drives psel/penable/command, receives response)
//   slave  : completer side (receives command, drives pready/prdata/pslverr)
interface apb_requester_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 16
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [STRB_WIDTH-1:0] pstrb;
    logic [2:0]            pprot;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_arb_watchdog.sv
// ACCESS-phase watchdog for the APB arbiter.
//   clk, rst_n : clock, async active-low reset
//   clear      : restart the count (SETUP entry)
//   tick       : one ACCESS cycle without pready
//   expired_c  : this tick brings the count to TIMEOUT_CYCLES
module apb_arb_watchdog
    import apb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expired_c
);

    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_WIDTH-1:0] cnt_q;

    // Saturating wait counter; the FSM leaves ACCESS on the expiring tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (tick && (cnt_q != CNT_WIDTH'(TIMEOUT_CYCLES))) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign expired_c = tick && (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_requester_arbiter.sv
// Registered, non-interleaving round-robin arbiter sharing one APB completer
// bus between two APB requesters. Optional watchdog (macro
// APB_ARB_TIMEOUT_EN) aborts an ACCESS phase that never sees pready and
// returns pslverr=1, prdata=0 to the requester.
//   pclk, preset_n : clock, async active-low reset
//   req0, req1     : upstream requester ports (req0 wins the first tie)
//   cpl            : shared downstream completer bus
//   busy           : transfer outstanding (SETUP/ACCESS/RESP)
//   grant          : requester currently or last granted
module apb_requester_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                           pclk,
    input  logic                           preset_n,
    apb_requester_arbiter_if.slave         req0,
    apb_requester_arbiter_if.slave         req1,
    apb_requester_arbiter_if.master        cpl,
    output logic                           busy,
    output logic                           grant
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_e            state_q, state_d;
    logic                  pick_c;
    logic                  expired_c;
    logic [DATA_WIDTH-1:0] rsp_rdata_c;
    logic                  rsp_err_c;

    logic                  grant_q, grant_d;
    logic                  busy_q, busy_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
    logic [2:0]            pprot_q, pprot_d;

    logic                  up0_pready_q, up0_pready_d;
    logic                  up0_pslverr_q, up0_pslverr_d;
    logic [DATA_WIDTH-1:0] up0_prdata_q, up0_prdata_d;
    logic                  up1_pready_q, up1_pready_d;
    logic                  up1_pslverr_q, up1_pslverr_d;
    logic [DATA_WIDTH-1:0] up1_prdata_q, up1_prdata_d;

`ifdef APB_ARB_TIMEOUT_EN
    logic wd_clear_c;
    logic wd_tick_c;

    assign wd_clear_c = (state_q == IDLE) && (state_d == SETUP);
    assign wd_tick_c  = (state_q == ACCESS) && !cpl.pready;

    apb_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (pclk),
        .rst_n     (preset_n),
        .clear     (wd_clear_c),
        .tick      (wd_tick_c),
        .expired_c (expired_c)
    );
`else
    assign expired_c = 1'b0;
`endif

    // Request selection: single requester wins, a tie goes to the one not last granted.
    always_comb begin
        pick_c = grant_q;
        if (req0.psel && req1.psel) begin
            pick_c = ~grant_q;
        end else if (req0.psel) begin
            pick_c = 1'b0;
        end else if (req1.psel) begin
            pick_c = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a real pready on the expiry edge is a normal completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req0.psel || req1.psel) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (cpl.pready || expired_c) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Completer response, or the abort response when the watchdog fired.
    always_comb begin
        rsp_rdata_c = cpl.pready ? cpl.prdata : '0;
        rsp_err_c   = cpl.pready ? cpl.pslverr : 1'b1;
    end

    // Next values of all registered outputs.
    always_comb begin
        grant_d       = grant_q;
        busy_d        = (state_d != IDLE);
        psel_d        = 1'b0;
        penable_d     = 1'b0;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        up0_pready_d  = 1'b0;
        up0_pslverr_d = 1'b0;
        up0_prdata_d  = '0;
        up1_pready_d  = 1'b0;
        up1_pslverr_d = 1'b0;
        up1_prdata_d  = '0;
        case (state_q)
            IDLE: begin
                if (state_d == SETUP) begin
                    grant_d = pick_c;
                    psel_d  = 1'b1;
                    if (pick_c) begin
                        pwrite_d = req1.pwrite;
                        paddr_d  = req1.paddr;
                        pwdata_d = req1.pwdata;
                        pstrb_d  = req1.pstrb;
                        pprot_d  = req1.pprot;
                    end else begin
                        pwrite_d = req0.pwrite;
                        paddr_d  = req0.paddr;
                        pwdata_d = req0.pwdata;
                        pstrb_d  = req0.pstrb;
                        pprot_d  = req0.pprot;
                    end
                end
            end
            SETUP: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (state_d == RESP) begin
                    // A requester that abandoned its psel gets no response.
                    if (!grant_q && req0.psel) begin
                        up0_pready_d  = 1'b1;
                        up0_prdata_d  = rsp_rdata_c;
                        up0_pslverr_d = rsp_err_c;
                    end
                    if (grant_q && req1.psel) begin
                        up1_pready_d  = 1'b1;
                        up1_prdata_d  = rsp_rdata_c;
                        up1_pslverr_d = rsp_err_c;
                    end
                end else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            grant_q       <= 1'b1;
            busy_q        <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            up0_pready_q  <= 1'b0;
            up0_pslverr_q <= 1'b0;
            up0_prdata_q  <= '0;
            up1_pready_q  <= 1'b0;
            up1_pslverr_q <= 1'b0;
            up1_prdata_q  <= '0;
        end else begin
            grant_q       <= grant_d;
            busy_q        <= busy_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
            up0_pready_q  <= up0_pready_d;
            up0_pslverr_q <= up0_pslverr_d;
            up0_prdata_q  <= up0_prdata_d;
            up1_pready_q  <= up1_pready_d;
            up1_pslverr_q <= up1_pslverr_d;
            up1_prdata_q  <= up1_prdata_d;
        end
    end

    assign grant        = grant_q;
    assign busy         = busy_q;

    assign cpl.psel     = psel_q;
    assign cpl.penable  = penable_q;
    assign cpl.pwrite   = pwrite_q;
    assign cpl.paddr    = paddr_q;
    assign cpl.pwdata   = pwdata_q;
    assign cpl.pstrb    = pstrb_q;
    assign cpl.pprot    = pprot_q;

    assign req0.pready  = up0_pready_q;
    assign req0.prdata  = up0_prdata_q;
    assign req0.pslverr = up0_pslverr_q;
    assign req1.pready  = up1_pready_q;
    assign req1.prdata  = up1_prdata_q;
    assign req1.pslverr = up1_pslverr_q;

endmodule

// File: tb/tb_apb_requester_arbiter.sv
// Directed bench for apb_requester_arbiter: two scripted requesters and a
// behavioural completer with programmable wait states, error and read data.
module tb_apb_requester_arbiter;

    logic pclk     = 1'b0;
    logic preset_n = 1'b1;
    logic busy;
    logic grant;

    apb_requester_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) r0 ();
    apb_requester_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) r1 ();
    apb_requester_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) c ();

    apb_requester_arbiter #(
        .DATA_WIDTH     (16),
        .ADDR_WIDTH     (10),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .req0     (r0),
        .req1     (r1),
        .cpl      (c),
        .busy     (busy),
        .grant    (grant)
    );

    always #5 pclk = ~pclk;

    // Completer model
    bit [15:0]   cfg_rdata = 16'h0;
    int          cfg_wait  = 0;
    bit          cfg_err   = 1'b0;
    bit          cfg_hang  = 1'b0;
    bit          cfg_echo  = 1'b0;
    int          wcnt      = 0;
    logic [9:0]  log_addr[$];
    logic [15:0] log_wdata[$];
    logic        grant_log[$];

    assign c.pready  = c.psel && c.penable && !cfg_hang && (wcnt >= cfg_wait);
    assign c.prdata  = cfg_echo ? (16'h1000 + 16'(c.paddr)) : cfg_rdata;
    assign c.pslverr = c.pready && cfg_err;

    always @(posedge pclk) begin
        if (c.psel && c.penable && !c.pready) wcnt <= wcnt + 1;
        else                                  wcnt <= 0;
        if (c.psel && c.penable && c.pready) begin
            log_addr.push_back(c.paddr);
            log_wdata.push_back(c.pwdata);
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic clear_logs();
        log_addr.delete();
        log_wdata.delete();
        grant_log.delete();
    endtask

    task automatic do_reset();
        preset_n = 1'b0;
        tick();
        tick();
        preset_n = 1'b1;
        tick();
    endtask

    // One transfer on one requester. lat = edges from psel to the edge where
    // the requester samples pready.
    task automatic do_xfer(input int idx, input logic wr, input logic [9:0] addr,
                           input logic [15:0] wd, input int budget,
                           output logic [15:0] rd, output logic er, output int lat,
                           output int pen_cnt, output int psel_at, output int pen_at,
                           output bit other_seen);
        bit done;
        done = 1'b0; rd = '0; er = 1'b0; lat = 0; pen_cnt = 0;
        psel_at = 0; pen_at = 0; other_seen = 1'b0;
        if (idx == 0) begin
            r0.pwrite = wr; r0.paddr = addr; r0.pwdata = wd; r0.psel = 1'b1;
        end else begin
            r1.pwrite = wr; r1.paddr = addr; r1.pwdata = wd; r1.psel = 1'b1;
        end
        while (!done && lat < budget) begin
            tick();
            lat++;
            if (c.psel && psel_at == 0)    psel_at = lat;
            if (c.penable && pen_at == 0)  pen_at = lat;
            if (c.penable)                 pen_cnt++;
            if (idx == 0) begin
                if (r1.pready || r1.pslverr || r1.prdata != 16'h0) other_seen = 1'b1;
                if (r0.pready) begin rd = r0.prdata; er = r0.pslverr; done = 1'b1; end
            end else begin
                if (r0.pready || r0.pslverr || r0.prdata != 16'h0) other_seen = 1'b1;
                if (r1.pready) begin rd = r1.prdata; er = r1.pslverr; done = 1'b1; end
            end
        end
        lat = lat + 1;
        check("xfer_done", 32'(done), 32'd1);
        r0.psel = 1'b0;
        r1.psel = 1'b0;
    endtask

    // Both requesters issue n back-to-back transfers from their base addresses.
    task automatic run_both(input logic [9:0] base0, input logic [9:0] base1, input int n,
                            input logic wr, input int budget,
                            output int got0, output int got1, output int bad);
        int cyc;
        logic [9:0] a0, a1;
        got0 = 0; got1 = 0; bad = 0; cyc = 0; a0 = base0; a1 = base1;
        r0.pwrite = wr; r0.paddr = a0; r0.pwdata = 16'hA000 | 16'(a0); r0.psel = 1'b1;
        r1.pwrite = wr; r1.paddr = a1; r1.pwdata = 16'hA000 | 16'(a1); r1.psel = 1'b1;
        while ((got0 < n || got1 < n) && cyc < budget) begin
            tick();
            cyc++;
            if (c.psel && !c.penable) grant_log.push_back(grant);
            if (r0.pready) begin
                got0++;
                if (!wr && r0.prdata !== (16'h1000 + 16'(a0))) bad++;
                a0 = a0 + 10'd1;
                if (got0 < n) begin r0.paddr = a0; r0.pwdata = 16'hA000 | 16'(a0); end
                else r0.psel = 1'b0;
            end
            if (r1.pready) begin
                got1++;
                if (!wr && r1.prdata !== (16'h1000 + 16'(a1))) bad++;
                a1 = a1 + 10'd1;
                if (got1 < n) begin r1.paddr = a1; r1.pwdata = 16'hA000 | 16'(a1); end
                else r1.psel = 1'b0;
            end
        end
        repeat (6) begin
            tick();
            if (r0.pready) got0++;
            if (r1.pready) got1++;
        end
        r0.psel = 1'b0;
        r1.psel = 1'b0;
    endtask

    initial begin
        logic [15:0] rd;
        logic        er;
        int          lat, pen, psel_at, pen_at, g0, g1, bad;
        bit          oth;
        logic [9:0]  exp_addr;

        r0.psel = 1'b0; r0.penable = 1'b0; r0.pwrite = 1'b0; r0.paddr = '0;
        r0.pwdata = '0; r0.pstrb = '1; r0.pprot = '0;
        r1.psel = 1'b0; r1.penable = 1'b0; r1.pwrite = 1'b0; r1.paddr = '0;
        r1.pwdata = '0; r1.pstrb = '1; r1.pprot = '0;

        // Reset state
        #3 preset_n = 1'b0;
        #1;
        check("rst_cpl_psel",    32'(c.psel),     32'd0);
        check("rst_cpl_penable", 32'(c.penable),  32'd0);
        check("rst_cpl_pwrite",  32'(c.pwrite),   32'd0);
        check("rst_cpl_paddr",   32'(c.paddr),    32'd0);
        check("rst_cpl_pwdata",  32'(c.pwdata),   32'd0);
        check("rst_busy",        32'(busy),       32'd0);
        check("rst_grant",       32'(grant),      32'd1);
        check("rst_r0_pready",   32'(r0.pready),  32'd0);
        check("rst_r1_pready",   32'(r1.pready),  32'd0);
        tick();
        tick();
        preset_n = 1'b1;
        tick();

        // Single read, zero wait states
        cfg_rdata = 16'hBEEF; cfg_wait = 0; cfg_err = 1'b0; cfg_echo = 1'b0;
        clear_logs();
        do_xfer(0, 1'b0, 10'h004, 16'h0, 20, rd, er, lat, pen, psel_at, pen_at, oth);
        check("rd_latency",   32'(lat),     32'd4);
        check("rd_psel_at",   32'(psel_at), 32'd1);
        check("rd_pen_at",    32'(pen_at),  32'd2);
        check("rd_prdata",    32'(rd),      32'h0000BEEF);
        check("rd_pslverr",   32'(er),      32'd0);
        check("rd_other_idle",32'(oth),     32'd0);
        check("rd_grant",     32'(grant),   32'd0);
        check("rd_busy_resp", 32'(busy),    32'd1);
        check("rd_log_size",  32'(log_addr.size()), 32'd1);
        check("rd_log_addr",  32'(log_addr[0]), 32'h004);
        tick();
        check("rd_busy_idle", 32'(busy),    32'd0);

        // Simultaneous writes out of reset
        do_reset();
        clear_logs();
        run_both(10'h123, 10'h2A0, 1, 1'b1, 40, g0, g1, bad);
        check("sim_r0_pulses", 32'(g0), 32'd1);
        check("sim_r1_pulses", 32'(g1), 32'd1);
        check("sim_log_size",  32'(log_addr.size()), 32'd2);
        check("sim_addr0",     32'(log_addr[0]),  32'h123);
        check("sim_addr1",     32'(log_addr[1]),  32'h2A0);
        check("sim_wdata0",    32'(log_wdata[0]), 32'hA123);
        check("sim_wdata1",    32'(log_wdata[1]), 32'hA2A0);
        check("sim_grant0",    32'(grant_log[0]), 32'd0);
        check("sim_grant1",    32'(grant_log[1]), 32'd1);

        // Sustained contention, 8 reads each
        clear_logs();
        cfg_echo = 1'b1;
        run_both(10'h100, 10'h200, 8, 1'b0, 200, g0, g1, bad);
        check("rr_r0_count",  32'(g0),  32'd8);
        check("rr_r1_count",  32'(g1),  32'd8);
        check("rr_rdata_bad", 32'(bad), 32'd0);
        check("rr_log_size",  32'(log_addr.size()), 32'd16);
        for (int k = 0; k < 16; k++) begin
            exp_addr = ((k % 2) == 0) ? (10'h100 + 10'(k / 2)) : (10'h200 + 10'(k / 2));
            check($sformatf("rr_addr%0d", k),  32'(log_addr[k]),  32'(exp_addr));
            check($sformatf("rr_grant%0d", k), 32'(grant_log[k]), 32'(k % 2));
        end
        cfg_echo = 1'b0;

        // Wait states with slave error on requester 1
        tick();
        cfg_rdata = 16'h5A5A; cfg_wait = 5; cfg_err = 1'b1;
        do_xfer(1, 1'b0, 10'h3C0, 16'h0, 30, rd, er, lat, pen, psel_at, pen_at, oth);
        check("ws_latency",    32'(lat),   32'd9);
        check("ws_penable",    32'(pen),   32'd6);
        check("ws_pslverr",    32'(er),    32'd1);
        check("ws_prdata",     32'(rd),    32'h00005A5A);
        check("ws_other_idle", 32'(oth),   32'd0);
        check("ws_grant",      32'(grant), 32'd1);
        cfg_wait = 0; cfg_err = 1'b0;
        tick();

`ifdef APB_ARB_TIMEOUT_EN
        // Watchdog abort, then a normal transfer
        cfg_hang = 1'b1; cfg_rdata = 16'h1234;
        do_xfer(0, 1'b0, 10'h010, 16'h0, 40, rd, er, lat, pen, psel_at, pen_at, oth);
        check("wd_latency",  32'(lat),    32'd19);
        check("wd_penable",  32'(pen),    32'd16);
        check("wd_pslverr",  32'(er),     32'd1);
        check("wd_prdata",   32'(rd),     32'd0);
        check("wd_cpl_psel", 32'(c.psel), 32'd0);
        cfg_hang = 1'b0;
        tick();
        do_xfer(0, 1'b0, 10'h011, 16'h0, 20, rd, er, lat, pen, psel_at, pen_at, oth);
        check("wd_next_latency", 32'(lat), 32'd4);
        check("wd_next_prdata",  32'(rd),  32'h00001234);
        check("wd_next_pslverr", 32'(er),  32'd0);
        tick();
`endif

        // Reset during ACCESS
        cfg_wait = 3;
        r0.pwrite = 1'b0; r0.paddr = 10'h055; r0.psel = 1'b1;
        tick();
        tick();
        check("mr_in_access", 32'(c.penable), 32'd1);
        check("mr_busy_pre",  32'(busy),      32'd1);
        preset_n = 1'b0;
        #1;
        check("mr_cpl_psel",    32'(c.psel),    32'd0);
        check("mr_cpl_penable", 32'(c.penable), 32'd0);
        check("mr_busy",        32'(busy),      32'd0);
        check("mr_grant",       32'(grant),     32'd1);
        check("mr_r0_pready",   32'(r0.pready), 32'd0);
        r0.psel = 1'b0;
        tick();
        preset_n = 1'b1;
        tick();
        cfg_wait = 0; cfg_rdata = 16'h7777;
        clear_logs();
        do_xfer(0, 1'b0, 10'h056, 16'h0, 20, rd, er, lat, pen, psel_at, pen_at, oth);
        check("mr_after_latency", 32'(lat), 32'd4);
        check("mr_after_prdata",  32'(rd),  32'h00007777);
        check("mr_after_pslverr", 32'(er),  32'd0);
        check("mr_after_log",     32'(log_addr.size()), 32'd1);
        check("mr_after_addr",    32'(log_addr[0]), 32'h056);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
